mips_instr_encoder: RTL and testbench

//  Inverse of the instruction decoder: turns a decoded-form request (decoded_op_t + register fields +

---
 rtl/mips_instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Purpose: encode decoded-form MIPS requests into raw 32-bit words tagged with sequential fetch addresses.
// Latency: a request accepted at edge N is visible at the FIFO head (out_valid=1) right after edge N.
// Backpressure: in_ready = !full (no pop bypass); the head holds stable while out_valid && !out_ready.

package mips_pkg;
  typedef enum logic [4:0] {
    D_ADDU, D_SUBU, D_SLT, D_SLTU, D_AND, D_NOR, D_OR, D_XOR,
    D_SLL, D_SRA, D_SRL, D_JR, D_LUI, D_BEQ, D_BNE, D_LW, D_SW,
    D_J, D_JAL, D_RESERVED
  } decoded_op_t;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_RT    = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
endpackage

module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hBFC0_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  decoded_op_t in_op,
  input  logic        in_useimm,
  input  creg_addr_t  in_rs,
  input  creg_addr_t  in_rt,
  input  creg_addr_t  in_rd,
  input  logic [15:0] in_imm,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_instr,
  output logic [31:0] out_addr,
  output logic        err_sticky,
  output logic [7:0]  err_count
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    L_FULL     = (AW+1)'(DEPTH);
  localparam logic [AW:0]    L_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  L_PTR_ONE  = AW'(1);

  word_t          r_mem_instr [DEPTH];
  logic [31:0]    r_mem_addr  [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [31:0]    r_addr;
  logic           r_err_sticky;
  logic [7:0]     r_err_count;

  word_t          w_instr;
  logic           w_reject;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;

  // Encode the request; anything without a legal encoding is flagged for rejection.
  always_comb begin
    w_instr  = '0;
    w_reject = 1'b0;
    case (in_op)
      D_ADDU: w_instr = in_useimm ? {OP_ADDIU, in_rs, in_rt, in_imm}
                                  : {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_ADDU};
      D_SLT:  w_instr = in_useimm ? {OP_SLTI, in_rs, in_rt, in_imm}
                                  : {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_SLT};
      D_SLTU: w_instr = in_useimm ? {OP_SLTIU, in_rs, in_rt, in_imm}
                                  : {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_SLTU};
      D_AND:  w_instr = in_useimm ? {OP_ANDI, in_rs, in_rt, in_imm}
                                  : {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_AND};
      D_OR:   w_instr = in_useimm ? {OP_ORI, in_rs, in_rt, in_imm}
                                  : {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_OR};
      D_SUBU: begin w_reject = in_useimm; w_instr = {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_SUBU}; end
      D_NOR:  begin w_reject = in_useimm; w_instr = {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_NOR};  end
      D_XOR:  begin w_reject = in_useimm; w_instr = {OP_RT, in_rs, in_rt, in_rd, 5'b0, F_XOR};  end
      D_SLL:  begin w_reject = in_useimm; w_instr = {OP_RT, 5'b0, in_rt, in_rd, in_shamt, F_SLL}; end
      D_SRA:  begin w_reject = in_useimm; w_instr = {OP_RT, 5'b0, in_rt, in_rd, in_shamt, F_SRA}; end
      D_SRL:  begin w_reject = in_useimm; w_instr = {OP_RT, 5'b0, in_rt, in_rd, in_shamt, F_SRL}; end
      D_JR:   begin w_reject = in_useimm; w_instr = {OP_RT, in_rs, 15'b0, F_JR}; end
      D_LUI:  w_instr = {OP_LUI, 5'b0, in_rt, in_imm};
      D_BEQ:  w_instr = {OP_BEQ, in_rs, in_rt, in_imm};
      D_BNE:  w_instr = {OP_BNE, in_rs, in_rt, in_imm};
      D_LW:   w_instr = {OP_LW, in_rs, in_rt, in_imm};
      D_SW:   w_instr = {OP_SW, in_rs, in_rt, in_imm};
      D_J:    w_instr = {OP_J, in_target};
      D_JAL:  w_instr = {OP_JAL, in_target};
      default: w_reject = 1'b1;
    endcase
  end

  // Handshake qualification; flush suppresses every state change of the cycle except the clear.
  always_comb begin
    in_ready = (r_count != L_FULL);
    w_accept = in_valid && in_ready;
    w_push   = w_accept && !w_reject && !flush;
    w_pop    = out_valid && out_ready && !flush;
  end

  // FIFO storage, pointers, occupancy and the fetch-address counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_addr[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= w_instr;
        r_mem_addr[r_wr_ptr]  <= r_addr;
        r_wr_ptr              <= r_wr_ptr + L_PTR_ONE;
        r_addr                <= r_addr + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Rejected-request tracking; only reset clears it, and a flushed request is never an error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= 8'h00;
    end else if (w_accept && w_reject && !flush) begin
      r_err_sticky <= 1'b1;
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end
  end

  // Head of the FIFO drives the output directly.
  always_comb begin
    out_valid  = (r_count != '0);
    out_instr  = r_mem_instr[r_rd_ptr];
    out_addr   = r_mem_addr[r_rd_ptr];
    err_sticky = r_err_sticky;
    err_count  = r_err_count;
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: vector table plus hand-written backpressure, flush and reset sequences.
// Expected words/addresses queue up when a request is accepted and are compared as the DUT pops them.
module tb_mips_instr_encoder;
  import mips_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  decoded_op_t in_op;
  logic        in_useimm;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [4:0]  in_shamt;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_sticky;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  mips_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_useimm(in_useimm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_shamt(in_shamt), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  typedef struct {
    decoded_op_t op;
    logic        useimm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [25:0] target;
    logic        rej;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [31:0] exp_addr;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(input decoded_op_t op, input logic ui, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                              input logic [4:0] sh, input logic [25:0] tgt, input logic rej,
                              input logic [31:0] exp);
    vec_t v;
    v.op = op; v.useimm = ui; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm;
    v.shamt = sh; v.target = tgt; v.rej = rej; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request and wait (bounded) for it to be taken.
  task automatic drive(input vec_t v);
    bit ok = 0;
    in_op = v.op; in_useimm = v.useimm; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_imm = v.imm; in_shamt = v.shamt; in_target = v.target; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (ok) begin
      if (!v.rej) begin
        sb.push_back('{v.exp, exp_addr});
        exp_addr = exp_addr + 32'd4;
      end
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin done = 1; break; end
    end
    if (!done) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
    chk("empty_after_drain", {31'd0, out_valid}, 32'd0);
  endtask

  // Scoreboard: every pop must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out_instr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_addr", out_addr, e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrej;
    logic [31:0] head_exp;
    // Table: ops, register fields and hand-encoded words.
    tbl.push_back(mk(D_ADDU, 0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h00221821));
    tbl.push_back(mk(D_ADDU, 1, 0, 8, 0, 16'h0005, 0, 0, 0, 32'h24080005));
    tbl.push_back(mk(D_SLL,  0, 0, 1, 2, 16'h0000, 4, 0, 0, 32'h00011100));
    tbl.push_back(mk(D_LW,   0, 29, 2, 0, 16'h0004, 0, 0, 0, 32'h8FA20004));
    tbl.push_back(mk(D_JAL,  0, 0, 0, 0, 16'h0000, 0, 26'h0100000, 0, 32'h0C100000));
    tbl.push_back(mk(D_SUBU, 0, 4, 5, 6, 16'hABCD, 0, 0, 0, 32'h00853023));
    tbl.push_back(mk(D_SRA,  0, 9, 7, 8, 16'hFFFF, 31, 0, 0, 32'h000747C3));
    tbl.push_back(mk(D_JR,   0, 31, 1, 2, 16'h0000, 3, 0, 0, 32'h03E00008));
    tbl.push_back(mk(D_OR,   1, 1, 2, 0, 16'hFFFF, 0, 0, 0, 32'h3422FFFF));
    tbl.push_back(mk(D_LUI,  0, 5, 3, 0, 16'h1234, 0, 0, 0, 32'h3C031234));
    tbl.push_back(mk(D_BEQ,  0, 1, 2, 0, 16'hFFFE, 0, 0, 0, 32'h1022FFFE));
    tbl.push_back(mk(D_BNE,  0, 3, 4, 0, 16'h0010, 0, 0, 0, 32'h14640010));
    tbl.push_back(mk(D_SW,   0, 29, 31, 0, 16'h0008, 0, 0, 0, 32'hAFBF0008));
    tbl.push_back(mk(D_J,    0, 0, 0, 0, 16'h0000, 0, 26'h3FFFFFF, 0, 32'h0BFFFFFF));
    tbl.push_back(mk(D_SLT,  1, 2, 3, 0, 16'h8000, 0, 0, 0, 32'h28438000));
    tbl.push_back(mk(D_NOR,  0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h00221827));
    tbl.push_back(mk(D_SRL,  0, 0, 1, 2, 16'h0000, 1, 0, 0, 32'h00011042));
    tbl.push_back(mk(D_SLTU, 1, 0, 1, 0, 16'h0001, 0, 0, 0, 32'h2C010001));
    tbl.push_back(mk(D_AND,  1, 1, 1, 0, 16'h00F0, 0, 0, 0, 32'h302100F0));
    tbl.push_back(mk(D_SLL,  1, 0, 1, 2, 16'h0000, 4, 0, 1, 32'h0));
    tbl.push_back(mk(D_AND,  0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h00221824));
    tbl.push_back(mk(D_XOR,  0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h00221826));
    tbl.push_back(mk(D_SLTU, 0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h0022182B));
    tbl.push_back(mk(D_NOR,  1, 1, 2, 3, 16'h0000, 0, 0, 1, 32'h0));
    tbl.push_back(mk(D_SLT,  0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h0022182A));
    tbl.push_back(mk(D_JR,   1, 31, 0, 0, 16'h0000, 0, 0, 1, 32'h0));
    tbl.push_back(mk(D_OR,   0, 1, 2, 3, 16'h0000, 0, 0, 0, 32'h00221825));

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = D_ADDU; in_useimm = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_shamt = '0; in_target = '0;
    exp_addr = BASE;

    // Reset state.
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Rejected requests: nothing enqueued, errors counted.
    drive(mk(D_RESERVED, 0, 1, 2, 3, 16'h0, 0, 0, 1, 32'h0));
    drive(mk(D_XOR, 1, 1, 2, 3, 16'h0, 0, 0, 1, 32'h0));
    chk("rej_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rej_err_sticky", {31'd0, err_sticky}, 32'd1);
    chk("rej_err_count", {24'd0, err_count}, 32'd2);

    // One-cycle latency of the first word, still at the base address.
    drive(tbl[0]);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_instr", out_instr, 32'h00221821);
    chk("lat_out_addr", out_addr, BASE);
    out_ready = 1'b1;
    drain();

    // Full table streamed back to back.
    nrej = 0;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      if (tbl[i].rej) nrej++;
    end
    drain();
    chk("tbl_err_count", {24'd0, err_count}, 32'(2 + nrej));

    // Backpressure: four fill the FIFO, the fifth waits until the consumer releases.
    out_ready = 1'b0;
    head_exp = exp_addr;
    for (int i = 0; i < 4; i++) drive(tbl[i]);
    @(negedge clk);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    fork
      drive(tbl[4]);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_head_instr", out_instr, tbl[0].exp);
          chk("bp_head_addr", out_addr, head_exp);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with a concurrent request: buffer emptied, request dropped without error.
    out_ready = 1'b0;
    drive(tbl[5]);
    drive(tbl[6]);
    in_op = D_RESERVED; in_useimm = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    exp_addr = BASE;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_err_count", {24'd0, err_count}, 32'(2 + nrej));
    out_ready = 1'b1;
    drive(tbl[9]);
    drain();

    // Asynchronous reset mid-cycle with three buffered entries.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(tbl[10 + i]);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_err_count", {24'd0, err_count}, 32'd0);
    chk("arst_err_sticky", {31'd0, err_sticky}, 32'd0);
    sb.delete();
    exp_addr = BASE;
    @(negedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(tbl[3]);
    drive(tbl[4]);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
